// File: rtl/pll_dyn_ctrl_if.sv
// Control/status bundle between the PLL controller and its user/rPLL.
interface pll_dyn_ctrl_if;
  logic       req_valid;
  logic [2:0] req_sel;
  logic       req_ready;
  logic       pll_lock;
  logic       pll_reset;
  logic [5:0] idsel;
  logic [5:0] fbdsel;
  logic [5:0] odsel;
  logic [2:0] cur_sel;
  logic       locked;
  logic       done;
  logic       err;
  logic       lock_lost;

  // Requester / PLL side
  modport master (
    output req_valid, req_sel, pll_lock,
    input  req_ready, pll_reset, idsel, fbdsel, odsel, cur_sel,
           locked, done, err, lock_lost
  );

  // Controller side
  modport slave (
    input  req_valid, req_sel, pll_lock,
    output req_ready, pll_reset, idsel, fbdsel, odsel, cur_sel,
           locked, done, err, lock_lost
  );
endinterface

// File: rtl/pll_dyn_ctrl.sv
// Dynamic rPLL reconfiguration: applies a divider preset, pulses the PLL
// reset, then waits for a debounced lock or a timeout.
module pll_dyn_ctrl #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_STABLE  = 8,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned INIT_SEL     = 0
) (
  input  logic           clk,
  input  logic           rst,
  pll_dyn_ctrl_if.slave  bus
);

  localparam int unsigned SEL_W = 3;
  localparam int unsigned DIV_W = 6;
  localparam int unsigned ODS_W = DIV_W + 1;
  localparam int unsigned ENC_W = 3 * DIV_W;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned TMO_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_PRST  = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  // Preset table -> {idsel, fbdsel, odsel} as the rPLL dynamic ports expect
  function automatic logic [ENC_W-1:0] f_encode(input logic [SEL_W-1:0] sel);
    logic [DIV_W-1:0] v_idiv;
    logic [DIV_W-1:0] v_fbdiv;
    logic [DIV_W-1:0] v_odiv;
    v_idiv  = '0;
    v_fbdiv = '0;
    v_odiv  = '0;
    case (sel)
      3'd0: begin v_idiv = 6'd8; v_fbdiv = 6'd33; v_odiv = 6'd8;  end
      3'd1: begin v_idiv = 6'd0; v_fbdiv = 6'd2;  v_odiv = 6'd8;  end
      3'd2: begin v_idiv = 6'd8; v_fbdiv = 6'd16; v_odiv = 6'd8;  end
      3'd3: begin v_idiv = 6'd3; v_fbdiv = 6'd10; v_odiv = 6'd8;  end
      3'd4: begin v_idiv = 6'd1; v_fbdiv = 6'd2;  v_odiv = 6'd16; end
      3'd5: begin v_idiv = 6'd8; v_fbdiv = 6'd49; v_odiv = 6'd4;  end
      3'd6: begin v_idiv = 6'd8; v_fbdiv = 6'd7;  v_odiv = 6'd32; end
      3'd7: begin v_idiv = 6'd7; v_fbdiv = 6'd2;  v_odiv = 6'd48; end
    endcase
    return {~v_idiv, ~v_fbdiv, DIV_W'(ODS_W'(64) - ODS_W'(v_odiv >> 1))};
  endfunction

  state_t             r_state, w_next;
  logic               r_sync1, r_lock_s;
  logic [CNT_W-1:0]   r_cnt, w_cnt;
  logic [CNT_W-1:0]   r_stab, w_stab;
  logic [TMO_W-1:0]   r_tmo, w_tmo;
  logic [SEL_W-1:0]   r_cur_sel, w_cur_sel;
  logic [ENC_W-1:0]   r_enc, w_enc;
  logic               r_pll_reset, w_pll_reset;
  logic               r_req_ready, w_req_ready;
  logic               r_locked, w_locked;
  logic               r_done, w_done;
  logic               r_err, w_err;
  logic               r_lost, w_lost;
  logic               w_stable_hit, w_timeout;

  assign w_stable_hit = r_lock_s && (r_stab == CNT_W'(LOCK_STABLE - 1));
  assign w_timeout    = (r_tmo == TMO_W'(LOCK_TIMEOUT - 1));

  // Two-flop synchroniser for the asynchronous PLL lock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_sync1  <= bus.pll_lock;
      r_lock_s <= r_sync1;
    end
  end

  // State register; reset lands in APPLY so the init preset runs unprompted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_APPLY;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.req_valid) w_next = S_APPLY;
      S_APPLY: w_next = S_PRST;
      S_PRST:  if (r_cnt == CNT_W'(RST_CYCLES - 1)) w_next = S_WAIT;
      S_WAIT:  if (w_stable_hit || w_timeout) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Next values of counters and registered outputs
  always_comb begin
    w_cnt       = '0;
    w_stab      = '0;
    w_tmo       = '0;
    w_cur_sel   = r_cur_sel;
    w_enc       = r_enc;
    w_locked    = r_locked;
    w_done      = 1'b0;
    w_err       = 1'b0;
    w_lost      = 1'b0;
    w_pll_reset = (w_next == S_APPLY) || (w_next == S_PRST);
    w_req_ready = (w_next == S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (r_locked && !r_lock_s) begin
          w_lost   = 1'b1;
          w_locked = 1'b0;
        end
        if (w_next == S_APPLY) begin
          w_cur_sel = bus.req_sel;
          w_enc     = f_encode(bus.req_sel);
          w_locked  = 1'b0;
        end
      end
      // APPLY is the first of the RST_CYCLES reset cycles
      S_APPLY: w_cnt = CNT_W'(1);
      S_PRST: begin
        if (w_next == S_PRST) w_cnt = r_cnt + CNT_W'(1);
      end
      S_WAIT: begin
        if (w_stable_hit) begin
          w_done   = 1'b1;
          w_locked = 1'b1;
        end else if (w_timeout) begin
          w_err    = 1'b1;
          w_locked = 1'b0;
        end else begin
          w_stab = r_lock_s ? (r_stab + CNT_W'(1)) : '0;
          w_tmo  = r_tmo + TMO_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Counter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_stab      <= '0;
      r_tmo       <= '0;
      r_cur_sel   <= SEL_W'(INIT_SEL);
      r_enc       <= f_encode(SEL_W'(INIT_SEL));
      r_pll_reset <= 1'b1;
      r_req_ready <= 1'b0;
      r_locked    <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_lost      <= 1'b0;
    end else begin
      r_cnt       <= w_cnt;
      r_stab      <= w_stab;
      r_tmo       <= w_tmo;
      r_cur_sel   <= w_cur_sel;
      r_enc       <= w_enc;
      r_pll_reset <= w_pll_reset;
      r_req_ready <= w_req_ready;
      r_locked    <= w_locked;
      r_done      <= w_done;
      r_err       <= w_err;
      r_lost      <= w_lost;
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.pll_reset = r_pll_reset;
  assign bus.idsel     = r_enc[ENC_W-1 -: DIV_W];
  assign bus.fbdsel    = r_enc[2*DIV_W-1 -: DIV_W];
  assign bus.odsel     = r_enc[DIV_W-1:0];
  assign bus.cur_sel   = r_cur_sel;
  assign bus.locked    = r_locked;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.lock_lost = r_lost;

endmodule
